// File: rtl/mac_pkg.sv
// Shared types and defaults for the multiply-accumulate stage.
package mac_pkg;

    localparam int unsigned PROD_W    = 16;
    localparam int unsigned ACC_W_DEF = 24;
    localparam int unsigned CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } mac_state_t;

endpackage

// File: rtl/mac_acc_add.sv
// Accumulator adder: acc + zero-extended product, with carry-out as overflow.
// Optional clamp to all-ones on overflow when MAC_ACC_SAT_EN is defined.
module mac_acc_add
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_i,
    input  logic [PROD_W-1:0] prod_i,
    output logic [ACC_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [ACC_W:0] wide_sum;

    always_comb begin
        wide_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
        ovf_o    = wide_sum[ACC_W];
`ifdef MAC_ACC_SAT_EN
        sum_o    = ovf_o ? '1 : wide_sum[ACC_W-1:0];
`else
        sum_o    = wide_sum[ACC_W-1:0];
`endif
    end

endmodule

// File: rtl/mac_accum_8bit.sv
// Block-wise accumulator of multiplier products with valid/ready result output.
// Saturating accumulator enabled by defining MAC_ACC_SAT_EN (default: wrap).
module mac_accum_8bit
    import mac_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] in_prod,
    input  logic              in_last,
    input  logic              clr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_acc,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_ovf
);

    mac_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;
    logic             accept;

    mac_acc_add #(
        .ACC_W (ACC_W)
    ) u_add (
        .acc_i  (acc_q),
        .prod_i (in_prod),
        .sum_o  (add_sum),
        .ovf_o  (add_ovf)
    );

    // in_ready depends on registered state and clr only.
    assign in_ready = (state_q != HOLD) && !clr;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, ACCUM: begin
                if (clr) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end else if (accept) begin
                    acc_d   = add_sum;
                    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
                    ovf_d   = ovf_q | add_ovf;
                    state_d = in_last ? HOLD : ACCUM;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = (state_q == HOLD);
    assign out_acc   = acc_q;
    assign out_count = cnt_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_mac_accum_8bit.sv
// Directed self-checking bench for mac_accum_8bit (default and ACC_W=17 instances).
module tb_mac_accum_8bit;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        in_valid, in_last, clr, out_ready;
    logic [15:0] in_prod;
    logic        in_ready, out_valid, out_ovf;
    logic [23:0] out_acc;
    logic [7:0]  out_count;

    logic        b_in_valid, b_in_last, b_clr, b_out_ready;
    logic [15:0] b_in_prod;
    logic        b_in_ready, b_out_valid, b_out_ovf;
    logic [16:0] b_out_acc;
    logic [7:0]  b_out_count;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    mac_accum_8bit u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_last   (in_last),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_acc   (out_acc),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    mac_accum_8bit #(
        .ACC_W (17),
        .CNT_W (8)
    ) u_dut17 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_prod   (b_in_prod),
        .in_last   (b_in_last),
        .clr       (b_clr),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_acc   (b_out_acc),
        .out_count (b_out_count),
        .out_ovf   (b_out_ovf)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] prod, input logic last);
        in_valid = 1'b1;
        in_prod  = prod;
        in_last  = last;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1'($urandom);
            in_last   = 1'($urandom);
            clr       = 1'($urandom);
            out_ready = 1'($urandom);
            in_prod   = 16'($urandom);
            b_in_valid  = 1'($urandom);
            b_in_last   = 1'($urandom);
            b_clr       = 1'($urandom);
            b_out_ready = 1'($urandom);
            b_in_prod   = 16'($urandom);
            tick();
        end
        check_val("rst_out_valid", 32'(out_valid), 32'h0);
        check_val("rst_out_acc",   32'(out_acc),   32'h0);
        check_val("rst_out_count", 32'(out_count), 32'h0);
        check_val("rst_out_ovf",   32'(out_ovf),   32'h0);

        in_valid = 1'b0; in_last = 1'b0; clr = 1'b0; out_ready = 1'b1; in_prod = '0;
        b_in_valid = 1'b0; b_in_last = 1'b0; b_clr = 1'b0; b_out_ready = 1'b1; b_in_prod = '0;
        rst_n = 1'b1;
        tick();
        check_val("post_rst_in_ready",  32'(in_ready),  32'h1);
        check_val("post_rst_out_valid", 32'(out_valid), 32'h0);

        // Basic block
        beat(16'h0001, 1'b0);
        beat(16'h00FF, 1'b0);
        beat(16'hFE01, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        check_val("basic_out_valid", 32'(out_valid), 32'h1);
        check_val("basic_out_acc",   32'(out_acc),   32'h00FF01);
        check_val("basic_out_count", 32'(out_count), 32'd3);
        check_val("basic_out_ovf",   32'(out_ovf),   32'h0);
        check_val("basic_in_ready_hold", 32'(in_ready), 32'h0);
        tick();
        check_val("basic_done_valid",    32'(out_valid), 32'h0);
        check_val("basic_done_in_ready", 32'(in_ready),  32'h1);

        // Backpressure
        out_ready = 1'b0;
        beat(16'h0001, 1'b0);
        beat(16'h00FF, 1'b0);
        beat(16'hFE01, 1'b1);
        in_prod = 16'h1234;
        for (int i = 0; i < 5; i++) begin
            check_val("bp_out_valid", 32'(out_valid), 32'h1);
            check_val("bp_out_acc",   32'(out_acc),   32'h00FF01);
            check_val("bp_out_count", 32'(out_count), 32'd3);
            check_val("bp_in_ready",  32'(in_ready),  32'h0);
            tick();
        end
        out_ready = 1'b1;
        in_valid  = 1'b0; in_last = 1'b0;
        tick();
        check_val("bp_hs_valid", 32'(out_valid), 32'h0);
        check_val("bp_hs_count", 32'(out_count), 32'd0);
        check_val("bp_hs_acc",   32'(out_acc),   32'h0);
        tick();
        check_val("bp_single_hs", 32'(out_valid), 32'h0);

        // Clear mid-block
        beat(16'h0010, 1'b0);
        beat(16'h0010, 1'b0);
        in_valid = 1'b1; in_prod = 16'h0007; in_last = 1'b0; clr = 1'b1;
        #1;
        check_val("clr_in_ready", 32'(in_ready), 32'h0);
        tick();
        clr = 1'b0;
        check_val("clr_acc_zero", 32'(out_acc), 32'h0);
        beat(16'h0005, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        check_val("clr_out_valid", 32'(out_valid), 32'h1);
        check_val("clr_out_acc",   32'(out_acc),   32'h5);
        check_val("clr_out_count", 32'(out_count), 32'd1);
        tick();

        // Overflow on the ACC_W=17 instance
        b_in_valid = 1'b1; b_in_prod = 16'hFE01; b_in_last = 1'b0;
        tick();
        tick();
        b_in_last = 1'b1;
        tick();
        b_in_valid = 1'b0; b_in_last = 1'b0;
        check_val("ovf_out_valid", 32'(b_out_valid), 32'h1);
        check_val("ovf_out_ovf",   32'(b_out_ovf),   32'h1);
        check_val("ovf_out_count", 32'(b_out_count), 32'd3);
`ifdef MAC_ACC_SAT_EN
        check_val("ovf_out_acc", 32'(b_out_acc), 32'h1FFFF);
`else
        check_val("ovf_out_acc", 32'(b_out_acc), 32'h0FA03);
`endif
        tick();
        check_val("ovf_cleared", 32'(b_out_ovf), 32'h0);

        // Asynchronous reset while result is held
        out_ready = 1'b0;
        beat(16'h0100, 1'b0);
        beat(16'h0200, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        check_val("hold_out_valid", 32'(out_valid), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_rst_valid", 32'(out_valid), 32'h0);
        check_val("async_rst_acc",   32'(out_acc),   32'h0);
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        tick();
        beat(16'h0003, 1'b1);
        in_valid = 1'b0; in_last = 1'b0;
        check_val("after_rst_acc",   32'(out_acc),   32'h3);
        check_val("after_rst_count", 32'(out_count), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
